// File: rtl/button_step_gen_if.sv
// rtl/button_step_gen_if.sv - step request interface from the button front end to the selection counter
// Purpose : carries the one-cycle increment/decrement requests and the debounced
//           button levels. The button block drives it (master), the selection
//           logic samples it every cycle (slave); there is no handshake.
// Signals : inc_pulse  - one-cycle step-up request
//           dec_pulse  - one-cycle step-down request
//           up_level   - debounced up button level
//           down_level - debounced down button level
interface button_step_gen_if;
   logic inc_pulse;
   logic dec_pulse;
   logic up_level;
   logic down_level;

   modport master (output inc_pulse, output dec_pulse, output up_level, output down_level);
   modport slave  (input  inc_pulse, input  dec_pulse, input  up_level, input  down_level);
endinterface

// File: rtl/button_step_gen.sv
// rtl/button_step_gen.sv - debounced up/down buttons to single-cycle step pulses with auto-repeat
// Purpose : synchronises and debounces two raw push buttons, emits one step pulse
//           per press, auto-repeats while a button is held and suppresses steps
//           while both buttons are down.
// Ports   : clk      - system clock, rising edge
//           rst_n    - asynchronous active-low reset
//           btn_up   - raw up button, active-high, asynchronous to clk
//           btn_down - raw down button, active-high, asynchronous to clk
//           step     - master side of button_step_gen_if (pulses and levels)
module button_step_gen #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter int REPEAT_DELAY    = 50_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000,
   parameter bit ENABLE_REPEAT   = 1'b1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                btn_up,
   input  logic                btn_down,
   button_step_gen_if.master   step
);
   localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);
   localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int HOLD_W   = $clog2(HOLD_MAX);

   localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] DELAY_LAST  = HOLD_W'(REPEAT_DELAY - 1);
   localparam logic [HOLD_W-1:0] PERIOD_LAST = HOLD_W'(REPEAT_PERIOD - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT    = '1;

   typedef enum logic [1:0] {IDLE, DELAY, REPEAT, LOCK} state_t;

   // Bit 0 is the up button, bit 1 the down button throughout.
   logic [1:0] sync1, sync2;
   logic [1:0] level, level_prev, rise;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 2'b00;
         sync2 <= 2'b00;
      end else begin
         sync1 <= {btn_down, btn_up};
         sync2 <= sync1;
      end
   end

   for (genvar b = 0; b < 2; b++) begin : g_db
      logic [DB_W-1:0] cnt;
      logic            lvl;

      // Any cycle agreeing with the current level restarts the run, so only
      // DEBOUNCE_CYCLES consecutive disagreeing samples flip the level.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
            lvl <= 1'b0;
         end else if (sync2[b] == lvl) begin
            cnt <= '0;
         end else if (cnt == DB_LAST) begin
            cnt <= '0;
            lvl <= ~lvl;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end

      assign level[b] = lvl;
   end

   assign rise = level & ~level_prev;

   state_t            state, state_nxt;
   logic              dir, dir_nxt;          // 0 = up, 1 = down
   logic [HOLD_W-1:0] hold_cnt;
   logic              inc_q, dec_q, inc_nxt, dec_nxt;
   logic              dir_lvl, other_rise, repeat_due;

   assign dir_lvl    = dir ? level[1] : level[0];
   assign other_rise = dir ? rise[0]  : rise[1];
   assign repeat_due = ENABLE_REPEAT &&
                       (((state == DELAY)  && (hold_cnt == DELAY_LAST)) ||
                        ((state == REPEAT) && (hold_cnt == PERIOD_LAST)));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         dir        <= 1'b0;
         level_prev <= 2'b00;
         inc_q      <= 1'b0;
         dec_q      <= 1'b0;
         hold_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         dir        <= dir_nxt;
         level_prev <= level;
         inc_q      <= inc_nxt;
         dec_q      <= dec_nxt;
         // Restart on every state change and on each repeat so the counter
         // always measures time since the last pulse; saturate otherwise.
         if ((state_nxt != state) || repeat_due)
            hold_cnt <= '0;
         else if (hold_cnt != HOLD_SAT)
            hold_cnt <= hold_cnt + 1'b1;
      end
   end

   always_comb begin
      state_nxt = state;
      dir_nxt   = dir;
      case (state)
         IDLE: begin
            if (&level) begin
               state_nxt = LOCK;
            end else if (rise[0]) begin
               state_nxt = DELAY;
               dir_nxt   = 1'b0;
            end else if (rise[1]) begin
               state_nxt = DELAY;
               dir_nxt   = 1'b1;
            end
         end
         DELAY, REPEAT: begin
            // A press of the opposite button outranks both release and a due repeat.
            if (other_rise)
               state_nxt = LOCK;
            else if (!dir_lvl)
               state_nxt = IDLE;
            else if (repeat_due)
               state_nxt = REPEAT;
         end
         LOCK: begin
            if (level == 2'b00)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      inc_nxt = 1'b0;
      dec_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (!(&level)) begin
               inc_nxt = rise[0];
               dec_nxt = rise[1] & ~rise[0];
            end
         end
         DELAY, REPEAT: begin
            if (!other_rise && dir_lvl && repeat_due) begin
               inc_nxt = ~dir;
               dec_nxt = dir;
            end
         end
         default: ;
      endcase
   end

   assign step.inc_pulse  = inc_q;
   assign step.dec_pulse  = dec_q;
   assign step.up_level   = level[0];
   assign step.down_level = level[1];
endmodule
